// File: rtl/timer_counter.sv
// Memory-mapped 32-bit countdown timer with CTRL/PRESET/COUNT registers.
// One-shot (mode 0, 2, 3) or auto-reload (mode 1); level IRQ gated by CTRL.IM.
module timer_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StCnt,
    StInt
  } state_e;

  localparam logic [1:0] RegCtrl   = 2'd0;
  localparam logic [1:0] RegPreset = 2'd1;
  localparam logic [1:0] RegCount  = 2'd2;

  state_e      state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        irq_flag_q, irq_flag_d;

  logic [1:0]  reg_sel;
  logic        wr_ctrl;
  logic        wr_preset;
  logic        enable;
  logic        auto_reload;
  logic        irq_set;
  logic        irq_clr;
  logic        unused_addr;

  assign reg_sel     = Addr[3:2];
  assign wr_ctrl     = WE && (reg_sel == RegCtrl);
  assign wr_preset   = WE && (reg_sel == RegPreset);
  assign enable      = ctrl_q[0];
  assign auto_reload = (ctrl_q[2:1] == 2'b01);
  assign unused_addr = ^{Addr[31:4], Addr[1:0]};

  // Expiry sets the flag even if a register write clears it in the same cycle.
  assign irq_set = (state_q == StCnt) && enable && (count_q <= 32'd1);
  assign irq_clr = wr_ctrl || wr_preset ||
                   ((state_q == StInt) && enable && auto_reload);

  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    preset_d = preset_q;
    count_d  = count_q;

    unique case (state_q)
      StIdle: begin
        if (enable) begin
          state_d = StLoad;
        end
      end
      StLoad: begin
        if (enable) begin
          count_d = preset_q;
          state_d = StCnt;
        end else begin
          state_d = StIdle;
        end
      end
      StCnt: begin
        if (!enable) begin
          state_d = StIdle;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          count_d = '0;
          state_d = StInt;
        end
      end
      StInt: begin
        if (!enable) begin
          state_d = StIdle;
        end else if (auto_reload) begin
          state_d = StLoad;
        end else begin
          ctrl_d[0] = 1'b0;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // CPU writes are applied last so they override the FSM's own Enable clear.
    if (wr_ctrl) begin
      ctrl_d = Din[3:0];
    end
    if (wr_preset) begin
      preset_d = Din;
    end

    if (irq_set) begin
      irq_flag_d = 1'b1;
    end else if (irq_clr) begin
      irq_flag_d = 1'b0;
    end else begin
      irq_flag_d = irq_flag_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      ctrl_q     <= '0;
      preset_q   <= '0;
      count_q    <= '0;
      irq_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
    end
  end

  always_comb begin
    Dout = '0;
    unique case (reg_sel)
      RegCtrl:   Dout = {28'd0, ctrl_q};
      RegPreset: Dout = preset_q;
      RegCount:  Dout = count_q;
      default:   Dout = '0;
    endcase
  end

  assign IRQ = ctrl_q[3] & irq_flag_q;

endmodule

// File: tb/tb_timer_counter.sv
// Scoreboard bench for timer_counter: expectations are queued before each edge
// and compared on the following falling edge.
module tb_timer_counter;

  localparam logic [31:0] ACtrl   = 32'h0;
  localparam logic [31:0] APreset = 32'h4;
  localparam logic [31:0] ACount  = 32'h8;
  localparam logic [31:0] AUnused = 32'hC;

  logic        clk;
  logic        reset;
  logic [31:0] Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] addr;
    logic [31:0] val;
    bit          is_irq;
  } exp_t;

  exp_t sb[$];

  timer_counter dut (
    .clk  (clk),
    .reset(reset),
    .Addr (Addr),
    .WE   (WE),
    .Din  (Din),
    .Dout (Dout),
    .IRQ  (IRQ)
  );

  initial begin
    clk = 1'b0;
    forever #20 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic push_reg(input string tag, input logic [31:0] a, input logic [31:0] v);
    exp_t e;
    e.tag    = tag;
    e.addr   = a;
    e.val    = v;
    e.is_irq = 1'b0;
    sb.push_back(e);
  endtask

  task automatic push_irq(input string tag, input logic v);
    exp_t e;
    e.tag    = tag;
    e.addr   = ACtrl;
    e.val    = {31'd0, v};
    e.is_irq = 1'b1;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e    = sb.pop_front();
      Addr = e.addr;
      #1;
      if (e.is_irq) check(e.tag, {31'd0, IRQ}, e.val);
      else          check(e.tag, Dout, e.val);
    end
  endtask

  // Drive one bus cycle, take the rising edge, then compare queued expectations.
  task automatic cycle(input logic we_v, input logic [31:0] a, input logic [31:0] d);
    WE   = we_v;
    Addr = a;
    Din  = d;
    @(posedge clk);
    #1;
    WE = 1'b0;
    @(negedge clk);
    drain();
  endtask

  task automatic idle();
    cycle(1'b0, 32'h0, 32'h0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    cycle(1'b1, a, d);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    WE    = 1'b0;
    Addr  = '0;
    Din   = '0;
    @(negedge clk);
    reset = 1'b0;

    // 1: asynchronous reset while counting
    wr(APreset, 32'd100);
    wr(ACtrl, 32'h9);
    idle();
    idle();
    push_reg("t1 pre ctrl", ACtrl, 32'h9);
    push_reg("t1 pre preset", APreset, 32'd100);
    push_reg("t1 pre count", ACount, 32'd99);
    idle();
    reset = 1'b1;
    push_reg("t1 rst ctrl", ACtrl, 32'h0);
    push_reg("t1 rst preset", APreset, 32'h0);
    push_reg("t1 rst count", ACount, 32'h0);
    push_irq("t1 rst irq", 1'b0);
    drain();
    reset = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      push_irq($sformatf("t1 post irq k=%0d", k), 1'b0);
      push_reg($sformatf("t1 post count k=%0d", k), ACount, 32'd0);
      idle();
    end

    // 2: one-shot, PRESET=5, IM=1
    do_reset();
    wr(APreset, 32'd5);
    wr(ACtrl, 32'h9);
    for (int k = 1; k <= 8; k++) begin
      push_reg($sformatf("t2 count k=%0d", k), ACount,
               (k >= 2 && k <= 6) ? 32'(7 - k) : 32'd0);
      push_irq($sformatf("t2 irq k=%0d", k), k >= 7);
      if (k == 8) push_reg("t2 ctrl after int", ACtrl, 32'h8);
      idle();
    end
    push_irq("t2 irq after preset write", 1'b0);
    wr(APreset, 32'd5);
    for (int k = 0; k < 2; k++) begin
      push_irq("t2 irq stays low", 1'b0);
      push_reg("t2 count stays 0", ACount, 32'd0);
      idle();
    end

    // 3: auto-reload, PRESET=3, period 5
    do_reset();
    wr(APreset, 32'd3);
    wr(ACtrl, 32'hB);
    for (int k = 1; k <= 16; k++) begin
      int p;
      logic [31:0] ec;
      p  = (k - 2) % 5;
      ec = (k < 2 || p >= 3) ? 32'd0 : 32'(3 - p);
      push_reg($sformatf("t3 count k=%0d", k), ACount, ec);
      push_irq($sformatf("t3 irq k=%0d", k), (k % 5) == 0);
      idle();
    end
    wr(ACtrl, 32'h0);

    // 4: IM=0 masks the interrupt
    do_reset();
    wr(APreset, 32'd10);
    wr(ACtrl, 32'h1);
    for (int k = 1; k <= 13; k++) begin
      push_irq($sformatf("t4 irq k=%0d", k), 1'b0);
      if (k == 11) push_reg("t4 count 1", ACount, 32'd1);
      if (k == 12) push_reg("t4 count 0", ACount, 32'd0);
      if (k == 13) push_reg("t4 enable cleared", ACtrl, 32'h0);
      idle();
    end
    push_irq("t4 irq after im set", 1'b0);
    push_reg("t4 ctrl 8", ACtrl, 32'h8);
    wr(ACtrl, 32'h8);
    push_irq("t4 irq later", 1'b0);
    idle();

    // 5a: pause in mode 1, then reload on re-enable
    do_reset();
    wr(APreset, 32'd8);
    wr(ACtrl, 32'hB);
    for (int k = 1; k <= 5; k++) begin
      push_reg($sformatf("t5a count k=%0d", k), ACount, (k >= 2) ? 32'(10 - k) : 32'd0);
      idle();
    end
    push_reg("t5a count at disable", ACount, 32'd4);
    wr(ACtrl, 32'hA);
    for (int k = 0; k < 4; k++) begin
      push_reg($sformatf("t5a hold %0d", k), ACount, 32'd4);
      push_irq($sformatf("t5a irq %0d", k), 1'b0);
      idle();
    end
    push_reg("t5a reenable", ACount, 32'd4);
    wr(ACtrl, 32'hB);
    push_reg("t5a load", ACount, 32'd4);
    idle();
    push_reg("t5a reload", ACount, 32'd8);
    idle();

    // 5b: PRESET write during CNT applies at the next reload
    do_reset();
    wr(APreset, 32'd4);
    wr(ACtrl, 32'hB);
    idle();
    push_reg("t5b count k=2", ACount, 32'd4);
    idle();
    push_reg("t5b count k=3", ACount, 32'd3);
    wr(APreset, 32'd7);
    push_reg("t5b count k=4", ACount, 32'd2);
    idle();
    push_reg("t5b count k=5", ACount, 32'd1);
    idle();
    push_reg("t5b count k=6", ACount, 32'd0);
    push_irq("t5b irq k=6", 1'b1);
    idle();
    push_irq("t5b irq k=7", 1'b0);
    idle();
    push_reg("t5b count k=8", ACount, 32'd7);
    push_reg("t5b preset", APreset, 32'd7);
    idle();
    push_reg("t5b count k=9", ACount, 32'd6);
    idle();
    wr(ACtrl, 32'h0);

    // 6: PRESET 0 and 1 expire immediately; COUNT and unused writes ignored
    do_reset();
    wr(APreset, 32'd0);
    wr(ACtrl, 32'h9);
    push_irq("t6 p0 irq k=1", 1'b0);
    idle();
    push_irq("t6 p0 irq k=2", 1'b0);
    push_reg("t6 p0 count k=2", ACount, 32'd0);
    idle();
    push_irq("t6 p0 irq k=3", 1'b1);
    push_reg("t6 p0 count k=3", ACount, 32'd0);
    idle();
    push_irq("t6 irq cleared", 1'b0);
    push_reg("t6 ctrl 8", ACtrl, 32'h8);
    wr(APreset, 32'd1);
    wr(ACtrl, 32'h9);
    push_irq("t6 p1 irq k=1", 1'b0);
    idle();
    push_irq("t6 p1 irq k=2", 1'b0);
    push_reg("t6 p1 count k=2", ACount, 32'd1);
    idle();
    push_irq("t6 p1 irq k=3", 1'b1);
    push_reg("t6 p1 count k=3", ACount, 32'd0);
    idle();
    push_reg("t6 count write ignored", ACount, 32'd0);
    push_irq("t6 irq kept", 1'b1);
    push_reg("t6 preset kept", APreset, 32'd1);
    wr(ACount, 32'h1234);
    push_reg("t6 unused reads 0", AUnused, 32'd0);
    push_reg("t6 ctrl unchanged", ACtrl, 32'h8);
    push_irq("t6 irq still set", 1'b1);
    wr(AUnused, 32'hFFFF_FFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/timer_counter.md
Name: timer_counter

Overview:
- Memory-mapped 32-bit countdown timer on the CPU bridge.
- Its IRQ output drives HWInt[2] of the coprocessor-0 interrupt logic.
- CPU programs the timer through three word registers: CTRL, PRESET and COUNT.
- A four-state FSM loads, counts and signals. Mode 0 is one-shot; mode 1 auto-reloads.

Parameters:
none

Ports:
clk    input   1   system clock, all state updates on rising edge
reset  input   1   asynchronous, active-high; clears all state
Addr   input   32  byte address from bridge; only Addr[3:2] decoded
WE     input   1   write enable for this device (bridge-qualified)
Din    input   32  write data
Dout   output  32  read data, combinational
IRQ    output  1   interrupt request, level, to HWInt[2]

Behaviour:
- Register map, by Addr[3:2]:
  - 0 = CTRL: [0] Enable, [2:1] Mode, [3] IM, upper bits read 0.
  - 1 = PRESET.
  - 2 = COUNT, read-only.
  - 3 = unused, reads 0.
- Dout = selected register, combinational, zero latency.
- Writes, when WE=1 at a rising edge:
  - Addr[3:2]=0: CTRL[3:0] <= Din[3:0].
  - Addr[3:2]=1: PRESET <= Din.
  - Addr[3:2]=2 or 3: write ignored.
- Any write to CTRL or PRESET clears irq_flag.
- IRQ = CTRL.IM & irq_flag.
- Mode 2 and mode 3 behave exactly as mode 0.
- Reset (asynchronous) does all of the following immediately:
  - CTRL=0, PRESET=0, COUNT=0, irq_flag=0, state=IDLE.
  - IRQ=0 and Dout reflects the zeroed registers.
  - Reset mid-count aborts the count with no IRQ.
- FSM states: IDLE, LOAD, CNT, INT. Transitions per edge:
  - IDLE: Enable=1 -> LOAD; otherwise stay.
  - LOAD: COUNT <= PRESET -> CNT. If Enable=0, go to IDLE instead and leave COUNT unchanged.
  - CNT, Enable=0 -> IDLE; COUNT holds its value (pause). Re-enabling reloads via LOAD.
  - CNT, Enable=1 and COUNT>1: COUNT <= COUNT-1, stay in CNT.
  - CNT, Enable=1 and COUNT<=1: COUNT <= 0, irq_flag <= 1, go to INT. PRESET=0 or 1 therefore also raises an interrupt.
  - INT, Mode 0: CTRL.Enable <= 0, go to IDLE. irq_flag stays set until a CTRL or PRESET write.
  - INT, Mode 1: irq_flag <= 0, go to LOAD. IRQ is a one-cycle pulse.
  - INT, Enable cleared by the CPU while in INT: go to IDLE in both modes. irq_flag is cleared by that CTRL write.
- Timing, with PRESET=N>=2 and CTRL written with Enable=1 at edge 0:
  - LOAD after edge 1.
  - COUNT=N after edge 2.
  - COUNT=1 after edge N+1.
  - INT and IRQ high after edge N+2.
  - Mode 1 period is N+2 cycles: next IRQ after edge 2N+4.
- Simultaneous events:
  - A CPU write to CTRL in the same cycle the FSM clears Enable: the CPU write value wins.
  - Flag clear by a write in the same cycle as flag set in CNT: the set wins.
  - A PRESET write during CNT does not alter the current count; it takes effect at the next LOAD.
- Arithmetic: COUNT is 32-bit unsigned and never decrements below 0. No wrap-around.

Test Plan:
1. Reset with all registers nonzero and state CNT -> all registers read 0 and IRQ=0 before the next clock edge; no IRQ afterwards with Enable=0.
2. PRESET=5, CTRL=0x9 (IM=1, mode 0, Enable=1) -> COUNT reads 5,4,3,2,1,0 after edges 2..7; IRQ rises after edge 7. After edge 8, CTRL reads 0x8 and IRQ is still 1. Write PRESET=5 -> IRQ=0 next cycle.
3. PRESET=3, CTRL=0xB (mode 1) -> IRQ is a single-cycle pulse after edges 5, 10 and 15 (period 5); COUNT reloads to 3 each time.
4. PRESET=10, mode 0, IM=0 -> count expires and irq_flag sets, but IRQ stays 0. A subsequent CTRL write of 0x8 leaves IRQ at 0 because that write clears the flag.
5. Mode 1 counting, CTRL write Enable=0 at COUNT=4 -> state IDLE, COUNT holds 4, no IRQ. PRESET=7 write during CNT in a separate run -> current period is unaffected; the next reload uses 7.
6. PRESET=0 and PRESET=1 with Enable=1, IM=1 -> IRQ rises after edge 3 in both cases; COUNT reads 0; writes to Addr 0x8 are ignored.
